memory_read_scheduler_rr: RTL
=============================

// Module: memory_read_scheduler_rr
// PURPOSE
// - Shares the single memory_read port between N requesters (basic blocks plus the CC port).
// - Round-robin selection, registered request stage, stall counter.
// - Sits between the engines' memory_read_iface ports and the shared memory.
// - Data is broadcast to all requesters. A requester knows it won only when its in_ready pulses.
// PARAMETERS
// - N                2   number of requesters; index N-1 is the CC port
// - DWIDTH          11   address width (MEMORY_ADDR_WIDTH)
// - STALL_CNT_WIDTH  8   width of the saturating stall counter
// PORTS
// - clk        in   1          clock, all state on rising edge
// - rst        in   1          asynchronous reset, active-high
// - in_valid   in   N          request valid per requester
// - in_data    in   N*DWIDTH   request address per requester; slice i = [i*DWIDTH +: DWIDTH]
// - in_ready   out  N          one-cycle accept/data-valid pulse to the granted requester
// - out_valid  out  1          request valid to memory
// - out_data   out  DWIDTH     registered address to memory
// - out_ready  in   1          memory accepts and returns data in this cycle
// - busy       out  1          a request is held on the output (state REQ)
// - stall_cnt  out  STALL_CNT_WIDTH   cycles the current request has waited for out_ready
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, out_valid=0, out_data=0, in_ready=0, busy=0, stall_cnt=0, last_grant=N-1.
//   - After reset, requester 0 has first priority.
// - FSM states: IDLE, REQ.
// - IDLE: if |in_valid, pick the first valid index scanning last_grant+1, +2, ... modulo N.
//   - Register its address into out_data and its index into grant.
//   - Set out_valid=1 and go to REQ.
//   - Latency from in_valid to out_valid is 1 cycle.
// - REQ: out_valid and out_data are held stable until out_ready=1.
//   - in_ready[g] = (state==REQ) & out_ready & (grant==g). This is combinational, in the handshake cycle only.
//   - On handshake, last_grant<=grant.
//   - Back-to-back: in the handshake cycle, repeat the IDLE selection with the grant bit masked from in_valid.
//     - If a request is found, load it and stay in REQ. out_valid stays 1, with no bubble.
//     - If none is found, out_valid<=0 and go to IDLE.
//   - If the granted requester drops in_valid before handshake, the request is not aborted. It completes, and in_ready still pulses.
// - stall_cnt: cleared when a new request is loaded. +1 each REQ cycle with out_ready=0. Saturates at all-ones and does not wrap.
// - busy = (state==REQ).
// - Fairness: with all requesters valid, each one is served once every N handshakes.
// - Requester protocol: hold in_valid and the address stable until in_ready; deassert the cycle after in_ready.
// - Single requester: re-granted on every handshake; its in_valid is masked only in the handshake cycle, so a 1-cycle gap is allowed.
// - Invalid index: out-of-range is impossible; grant is clamped to 0..N-1.
// CONFIGURATION
// - `MEM_SCHED_CC_PRIO_EN defined:
//   - Requester N-1 (CC port) has absolute priority whenever its in_valid=1, in both IDLE and back-to-back selection.
//   - last_grant is not updated by CC grants.
//   - The remaining requesters are round-robin among themselves.
// - Not defined: pure round-robin over all N requesters.
// TESTING
// - T1 N=2, reset, then in_valid=2'b11 held, out_ready=1 always:
//   - out_data alternates addr0, addr1, addr0, ... every cycle after the first.
//   - in_ready alternates 01/10; out_valid stays 1.
// - T2 single request on req1, out_ready=0 for 5 cycles then 1:
//   - out_valid=1 and out_data stable for 6 cycles.
//   - stall_cnt reads 5 in the handshake cycle; in_ready=2'b10 for exactly that cycle.
// - T3 STALL_CNT_WIDTH=3, out_ready=0 for 12 cycles: stall_cnt reaches 7 and stays 7, with no wrap.
// - T4 rst asserted mid-REQ:
//   - out_valid, busy and in_ready go to 0 immediately, without a clock edge.
//   - After release with in_valid=2'b11, req0 is granted first.
// - T5 `MEM_SCHED_CC_PRIO_EN, N=3, in_valid=3'b111 held, out_ready=1: in_ready=3'b100 every handshake.
//   - Then drop in_valid[2]: req0 and req1 alternate.
// - T6 req0 drops in_valid after being loaded, before out_ready: the transaction completes, and in_ready[0] pulses once.

Source files
------------

// File: rtl/memory_read_scheduler_rr_if.sv
// Request/response bundle between requesters, the read scheduler and the shared memory port.
// master = requester/memory side, slave = the scheduler.
interface memory_read_scheduler_rr_if #(
  parameter int N               = 2,
  parameter int DWIDTH          = 11,
  parameter int STALL_CNT_WIDTH = 8
);
  logic [N-1:0]               in_valid;
  logic [N*DWIDTH-1:0]        in_data;
  logic [N-1:0]               in_ready;
  logic                       out_valid;
  logic [DWIDTH-1:0]          out_data;
  logic                       out_ready;
  logic                       busy;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, stall_cnt
  );
endinterface

// File: rtl/memory_read_scheduler_rr.sv
// Round-robin arbiter sharing one memory read port among N requesters, registered request stage.
// Optional MEM_SCHED_CC_PRIO_EN: requester N-1 (CC port) gets absolute priority.
module memory_read_scheduler_rr #(
  parameter int N               = 2,
  parameter int DWIDTH          = 11,
  parameter int STALL_CNT_WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst,
  memory_read_scheduler_rr_if.slave bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;
  localparam logic [GW-1:0] LAST_RST = GW'(N - 1);

  logic [0:0]                 state_q, state_d;
  logic [GW-1:0]              grant_q, grant_d;
  logic [GW-1:0]              last_grant_q, last_grant_d;
  logic [DWIDTH-1:0]          out_data_q, out_data_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  logic          handshake;
  logic [N-1:0]  cand;
  logic [N-1:0]  rr_cand;
  logic [GW-1:0] scan_base;
  logic [GW-1:0] sel;
  logic [GW-1:0] sel_cl;
  logic          found;
  logic [N-1:0]  in_ready_c;

  always_comb handshake = (state_q == S_REQ) && bus.out_ready;

  // In the handshake cycle the outgoing grant is masked and becomes the new rotation base.
  always_comb begin
    cand      = bus.in_valid;
    scan_base = last_grant_q;
    if (handshake) begin
      cand[grant_q] = 1'b0;
`ifdef MEM_SCHED_CC_PRIO_EN
      if (grant_q != LAST_RST) scan_base = grant_q;
`else
      scan_base = grant_q;
`endif
    end
  end

  always_comb begin
    found   = 1'b0;
    sel     = '0;
    rr_cand = cand;
`ifdef MEM_SCHED_CC_PRIO_EN
    rr_cand[N-1] = 1'b0;
`endif
    for (int k = 1; k <= N; k++) begin
      if (!found && rr_cand[(int'(scan_base) + k) % N]) begin
        found = 1'b1;
        sel   = GW'((int'(scan_base) + k) % N);
      end
    end
`ifdef MEM_SCHED_CC_PRIO_EN
    // CC port wins outright, even straight after its own handshake.
    if (bus.in_valid[N-1]) begin
      found = 1'b1;
      sel   = LAST_RST;
    end
`endif
    sel_cl = (int'(sel) < N) ? sel : '0;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    stall_d      = stall_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_REQ;
          grant_d    = sel_cl;
          out_data_d = bus.in_data[int'(sel_cl)*DWIDTH +: DWIDTH];
          stall_d    = '0;
        end
      end
      S_REQ: begin
        if (handshake) begin
`ifdef MEM_SCHED_CC_PRIO_EN
          if (grant_q != LAST_RST) last_grant_d = grant_q;
`else
          last_grant_d = grant_q;
`endif
          if (found) begin
            grant_d    = sel_cl;
            out_data_d = bus.in_data[int'(sel_cl)*DWIDTH +: DWIDTH];
            stall_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (stall_q != '1) begin
          stall_d = stall_q + STALL_CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      out_data_q   <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    in_ready_c = '0;
    for (int g = 0; g < N; g++) begin
      in_ready_c[g] = handshake && (int'(grant_q) == g);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == S_REQ);
  assign bus.busy      = (state_q == S_REQ);
  assign bus.out_data  = out_data_q;
  assign bus.stall_cnt = stall_q;

endmodule
